// File: rtl/link_fanin_arbiter.sv
// Two-requester fan-in arbiter onto one shared link.
// A granted requester first sends NUM_ID identification words and then its
// data words. The message ends on an accepted word that carries the release
// flag, or it is aborted after TIMEOUT cycles without an accepted word.
// Ties between the two requesters are broken round-robin.
module link_fanin_arbiter #(
    parameter int WIDTH_DATA = 32,
    parameter int NUM_ID     = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            I_Req,
    output logic [1:0]            O_Ack,
    input  logic [1:0]            I_Valid,
    input  logic [1:0]            I_Rls,
    input  logic [WIDTH_DATA-1:0] I_Data0,
    input  logic [WIDTH_DATA-1:0] I_Data1,
    output logic                  O_Valid,
    output logic [WIDTH_DATA-1:0] O_Data,
    output logic                  O_is_ID,
    input  logic                  I_Nack,
    output logic [1:0]            O_Nack,
    output logic                  O_Sel,
    output logic                  O_is_Busy,
    output logic                  O_Err
);

    localparam int CNT_W = $clog2(NUM_ID + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_ID - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [7:0]       IDLE_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        SEND_ID = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             R_Sel;
    logic             R_Last;
    logic [CNT_W-1:0] R_Cnt;
    logic [7:0]       R_Idle;
    logic             R_Nack;

    logic             sel_next;
    logic             last_next;
    logic [CNT_W-1:0] cnt_next;
    logic [7:0]       idle_next;

    logic             active;
    logic             acc;
    logic             msg_end;
    logic             timeout_hit;
    logic             grant_req;
    logic             winner;

    // Decode the word handshake, message end, timeout and the INIT winner.
    always_comb begin
        active      = (state == SEND_ID) || (state == RUN);
        acc         = active & I_Valid[R_Sel] & ~R_Nack;
        msg_end     = acc & I_Rls[R_Sel];
        timeout_hit = active & ~acc & (R_Idle == IDLE_LAST);
        grant_req   = |I_Req;
        if (I_Req == 2'b11) begin
            winner = ~R_Last;
        end else begin
            winner = I_Req[1];
        end
    end

    // Next-state logic for the FSM and its owner, round-robin, ID and idle counters.
    always_comb begin
        state_next = state;
        sel_next   = R_Sel;
        last_next  = R_Last;
        cnt_next   = R_Cnt;
        idle_next  = R_Idle;
        case (state)
            INIT: begin
                if (grant_req) begin
                    state_next = SEND_ID;
                    sel_next   = winner;
                    cnt_next   = '0;
                    idle_next  = '0;
                end
            end
            SEND_ID: begin
                if (msg_end || timeout_hit) begin
                    state_next = INIT;
                    last_next  = R_Sel;
                    cnt_next   = '0;
                    idle_next  = '0;
                end else if (acc) begin
                    idle_next = '0;
                    if (R_Cnt == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = RUN;
                    end else begin
                        cnt_next = R_Cnt + CNT_ONE;
                    end
                end else begin
                    idle_next = R_Idle + 8'd1;
                end
            end
            RUN: begin
                if (msg_end || timeout_hit) begin
                    state_next = INIT;
                    last_next  = R_Sel;
                    cnt_next   = '0;
                    idle_next  = '0;
                end else if (acc) begin
                    idle_next = '0;
                end else begin
                    idle_next = R_Idle + 8'd1;
                end
            end
            default: begin
                state_next = INIT;
                cnt_next   = '0;
                idle_next  = '0;
            end
        endcase
    end

    // State register with synchronous reset; the downstream nack is registered every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= INIT;
            R_Sel  <= 1'b0;
            R_Last <= 1'b1;
            R_Cnt  <= '0;
            R_Idle <= '0;
            R_Nack <= 1'b0;
        end else begin
            state  <= state_next;
            R_Sel  <= sel_next;
            R_Last <= last_next;
            R_Cnt  <= cnt_next;
            R_Idle <= idle_next;
            R_Nack <= I_Nack;
        end
    end

    // Link outputs; reset forces them quiet at once so a grant is dropped immediately.
    always_comb begin
        O_Ack     = 2'b00;
        O_Valid   = 1'b0;
        O_Data    = '0;
        O_is_ID   = 1'b0;
        O_Nack    = 2'b11;
        O_Sel     = 1'b0;
        O_is_Busy = 1'b0;
        O_Err     = 1'b0;
        if (!reset) begin
            O_Sel = R_Sel;
            if ((state == INIT) && grant_req) begin
                O_Ack = winner ? 2'b10 : 2'b01;
            end
            if (active) begin
                O_Valid = I_Valid[R_Sel];
                if (I_Valid[R_Sel]) begin
                    O_Data = R_Sel ? I_Data1 : I_Data0;
                end
                O_is_ID       = (state == SEND_ID) & I_Valid[R_Sel];
                O_Nack[R_Sel] = I_Nack;
            end
            O_is_Busy = (state != INIT) & ~msg_end & ~timeout_hit;
            O_Err     = timeout_hit;
        end
    end

endmodule

// File: tb/tb_link_fanin_arbiter.sv
// Self-checking bench for link_fanin_arbiter: a fixed vector table, directed
// multi-cycle sequences and a randomized run against a message-level model.
module tb_link_fanin_arbiter;

    localparam int WIDTH_DATA = 32;
    localparam int NUM_ID     = 3;
    localparam int TIMEOUT    = 64;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [1:0]            I_Req;
    logic [1:0]            I_Valid;
    logic [1:0]            I_Rls;
    logic [WIDTH_DATA-1:0] I_Data0;
    logic [WIDTH_DATA-1:0] I_Data1;
    logic                  I_Nack;
    logic [1:0]            O_Ack;
    logic                  O_Valid;
    logic [WIDTH_DATA-1:0] O_Data;
    logic                  O_is_ID;
    logic [1:0]            O_Nack;
    logic                  O_Sel;
    logic                  O_is_Busy;
    logic                  O_Err;

    int assert_count = 0;
    int fail_count   = 0;

    // Message-level model: who owns the link, words accepted so far,
    // quiet cycles since the last accepted word, round-robin memory.
    int m_owner    = -1;
    int m_words    = 0;
    int m_quiet    = 0;
    int m_last     = 1;
    int m_sel_hold = 0;
    bit m_nack_prev = 1'b0;

    logic [1:0]            e_ack, e_nack;
    logic                  e_valid, e_id, e_busy, e_err, e_sel;
    logic [WIDTH_DATA-1:0] e_data;
    int                    e_winner;
    bit                    e_taken, e_finish, e_timeout;

    logic [1:0]            s_ack, s_nack;
    logic                  s_valid, s_id, s_busy, s_err, s_sel;
    logic [WIDTH_DATA-1:0] s_data;

    typedef struct {
        logic [1:0] req;
        logic [1:0] valid;
        logic [1:0] rls;
        logic       nack;
        logic [1:0] exp_ack;
        logic       exp_valid;
        logic       exp_id;
        logic       exp_busy;
        logic       exp_err;
        logic [1:0] exp_nack;
        logic       exp_sel;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vec [NVEC];

    link_fanin_arbiter #(
        .WIDTH_DATA(WIDTH_DATA),
        .NUM_ID    (NUM_ID),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .I_Req    (I_Req),
        .O_Ack    (O_Ack),
        .I_Valid  (I_Valid),
        .I_Rls    (I_Rls),
        .I_Data0  (I_Data0),
        .I_Data1  (I_Data1),
        .O_Valid  (O_Valid),
        .O_Data   (O_Data),
        .O_is_ID  (O_is_ID),
        .I_Nack   (I_Nack),
        .O_Nack   (O_Nack),
        .O_Sel    (O_Sel),
        .O_is_Busy(O_is_Busy),
        .O_Err    (O_Err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clock = ~clock;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void computeExpected();
        e_ack = 2'b00; e_nack = 2'b11; e_valid = 1'b0; e_id = 1'b0;
        e_busy = 1'b0; e_err = 1'b0; e_sel = 1'b0; e_data = '0;
        e_winner = -1; e_taken = 1'b0; e_finish = 1'b0; e_timeout = 1'b0;
        if (reset) return;
        e_sel = (m_sel_hold == 1);
        if (m_owner < 0) begin
            if (I_Req == 2'b11)      e_winner = 1 - m_last;
            else if (I_Req == 2'b01) e_winner = 0;
            else if (I_Req == 2'b10) e_winner = 1;
            if (e_winner >= 0) e_ack = 2'(1 << e_winner);
        end else begin
            e_valid   = I_Valid[m_owner];
            e_taken   = e_valid && !m_nack_prev;
            e_finish  = e_taken && I_Rls[m_owner];
            e_timeout = !e_taken && (m_quiet == TIMEOUT - 1);
            if (e_valid) e_data = (m_owner == 1) ? I_Data1 : I_Data0;
            e_id   = e_valid && (m_words < NUM_ID);
            e_nack[m_owner] = I_Nack;
            e_busy = !e_finish && !e_timeout;
            e_err  = e_timeout;
        end
    endfunction

    function automatic void modelAdvance();
        if (reset) begin
            m_owner = -1; m_words = 0; m_quiet = 0; m_last = 1;
            m_sel_hold = 0; m_nack_prev = 1'b0;
            return;
        end
        m_nack_prev = I_Nack;
        if (m_owner < 0) begin
            if (e_winner >= 0) begin
                m_owner = e_winner; m_sel_hold = e_winner; m_words = 0; m_quiet = 0;
            end
        end else if (e_finish || e_timeout) begin
            m_last  = m_owner;
            m_owner = -1;
        end else if (e_taken) begin
            m_words++;
            m_quiet = 0;
        end else begin
            m_quiet++;
        end
    endfunction

    task automatic checkOutput();
        checkValue("ack",   32'(s_ack),   32'(e_ack));
        checkValue("valid", 32'(s_valid), 32'(e_valid));
        checkValue("data",  s_data,       e_data);
        checkValue("is_id", 32'(s_id),    32'(e_id));
        checkValue("nack",  32'(s_nack),  32'(e_nack));
        checkValue("sel",   32'(s_sel),   32'(e_sel));
        checkValue("busy",  32'(s_busy),  32'(e_busy));
        checkValue("err",   32'(s_err),   32'(e_err));
    endtask

    task automatic applyStimulus(input logic rst, input logic [1:0] req, input logic [1:0] valid,
                                 input logic [1:0] rls, input logic nack);
        reset   = rst;
        I_Req   = req;
        I_Valid = valid;
        I_Rls   = rls;
        I_Nack  = nack;
        I_Data0 = $urandom;
        I_Data1 = $urandom;
    endtask

    // Sample on the falling edge, then advance the model on the rising edge.
    task automatic stepCycle(input bit use_model);
        @(negedge clock);
        computeExpected();
        s_ack = O_Ack; s_valid = O_Valid; s_data = O_Data; s_id = O_is_ID;
        s_nack = O_Nack; s_sel = O_Sel; s_busy = O_is_Busy; s_err = O_Err;
        if (use_model) checkOutput();
        @(posedge clock);
        modelAdvance();
        #1;
    endtask

    task automatic resetDut();
        applyStimulus(1'b1, 2'b11, 2'b11, 2'b11, 1'b0);
        stepCycle(1'b1);
        stepCycle(1'b1);
    endtask

    task automatic sendWords(input logic [1:0] valid, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 2'b00, valid, 2'b00, 1'b0);
            stepCycle(1'b1);
        end
    endtask

    initial begin
        int err_pulses;
        int err_cycle;
        int ack_cycle;
        bit got_ack;
        logic [1:0] pend;
        logic [1:0] rv, rr;
        logic rn, rrst;
        int silent;
        logic [WIDTH_DATA-1:0] exp_data;

        vec[0]  = '{2'b01, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0};
        vec[1]  = '{2'b00, 2'b01, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0};
        vec[2]  = '{2'b00, 2'b01, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0};
        vec[3]  = '{2'b00, 2'b01, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0};
        vec[4]  = '{2'b00, 2'b01, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0};
        vec[5]  = '{2'b00, 2'b01, 2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0};
        vec[6]  = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0};
        vec[7]  = '{2'b11, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0};
        vec[8]  = '{2'b00, 2'b10, 2'b10, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1};
        vec[9]  = '{2'b11, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1};
        vec[10] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0};

        $display("[TB] vector table");
        resetDut();
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(1'b0, vec[i].req, vec[i].valid, vec[i].rls, vec[i].nack);
            stepCycle(1'b0);
            exp_data = vec[i].exp_valid ? (vec[i].exp_sel ? I_Data1 : I_Data0) : '0;
            checkValue($sformatf("vec%0d_ack", i),   32'(s_ack),   32'(vec[i].exp_ack));
            checkValue($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vec[i].exp_valid));
            checkValue($sformatf("vec%0d_data", i),  s_data,       exp_data);
            checkValue($sformatf("vec%0d_is_id", i), 32'(s_id),    32'(vec[i].exp_id));
            checkValue($sformatf("vec%0d_busy", i),  32'(s_busy),  32'(vec[i].exp_busy));
            checkValue($sformatf("vec%0d_err", i),   32'(s_err),   32'(vec[i].exp_err));
            checkValue($sformatf("vec%0d_nack", i),  32'(s_nack),  32'(vec[i].exp_nack));
            checkValue($sformatf("vec%0d_sel", i),   32'(s_sel),   32'(vec[i].exp_sel));
        end

        $display("[TB] back-pressure in RUN");
        resetDut();
        applyStimulus(1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
        stepCycle(1'b1);
        sendWords(2'b01, NUM_ID + 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 2'b00, 2'b01, 2'b00, 1'b1);
            stepCycle(1'b1);
            checkValue("bp_owner_nack", 32'(s_nack), 32'(2'b11));
        end
        applyStimulus(1'b0, 2'b00, 2'b01, 2'b00, 1'b0);
        stepCycle(1'b1);
        applyStimulus(1'b0, 2'b00, 2'b01, 2'b01, 1'b0);
        stepCycle(1'b1);
        checkValue("bp_end_busy", 32'(s_busy), 32'(1'b0));

        $display("[TB] timeout with a pending requester");
        resetDut();
        applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
        stepCycle(1'b1);
        checkValue("to_first_ack", 32'(s_ack), 32'(2'b01));
        err_pulses = 0; err_cycle = -1; ack_cycle = -1; got_ack = 1'b0;
        for (int k = 1; k <= TIMEOUT + 4; k++) begin
            applyStimulus(1'b0, got_ack ? 2'b00 : 2'b10, 2'b00, 2'b00, 1'b0);
            stepCycle(1'b1);
            if (s_err) begin
                err_pulses++;
                if (err_cycle < 0) err_cycle = k;
            end
            if (!got_ack && (s_ack == 2'b10)) begin
                got_ack = 1'b1;
                ack_cycle = k;
            end
        end
        checkValue("to_err_pulses", 32'(err_pulses), 32'(1));
        checkValue("to_err_cycle", 32'(err_cycle), 32'(TIMEOUT));
        checkValue("to_regrant_cycle", 32'(ack_cycle), 32'(TIMEOUT + 1));

        $display("[TB] short message");
        resetDut();
        applyStimulus(1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
        stepCycle(1'b1);
        sendWords(2'b01, 1);
        applyStimulus(1'b0, 2'b00, 2'b01, 2'b01, 1'b0);
        stepCycle(1'b1);
        checkValue("short_err", 32'(s_err), 32'(1'b0));
        checkValue("short_busy", 32'(s_busy), 32'(1'b0));
        applyStimulus(1'b0, 2'b00, 2'b01, 2'b00, 1'b0);
        stepCycle(1'b1);
        checkValue("short_back_in_init", 32'(s_valid), 32'(1'b0));
        applyStimulus(1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
        stepCycle(1'b1);
        sendWords(2'b01, NUM_ID - 1);
        applyStimulus(1'b0, 2'b00, 2'b01, 2'b00, 1'b0);
        stepCycle(1'b1);
        checkValue("short_cnt_cleared_last_id", 32'(s_id), 32'(1'b1));

        $display("[TB] turnaround and reset in RUN");
        applyStimulus(1'b0, 2'b10, 2'b01, 2'b01, 1'b0);
        stepCycle(1'b1);
        checkValue("turn_no_same_cycle_ack", 32'(s_ack), 32'(2'b00));
        applyStimulus(1'b0, 2'b10, 2'b00, 2'b00, 1'b0);
        stepCycle(1'b1);
        checkValue("turn_next_ack", 32'(s_ack), 32'(2'b10));
        sendWords(2'b10, NUM_ID + 1);
        applyStimulus(1'b1, 2'b00, 2'b10, 2'b00, 1'b0);
        stepCycle(1'b1);
        applyStimulus(1'b0, 2'b00, 2'b10, 2'b00, 1'b0);
        stepCycle(1'b1);
        checkValue("rst_run_valid", 32'(s_valid), 32'(1'b0));
        checkValue("rst_run_nack", 32'(s_nack), 32'(2'b11));
        checkValue("rst_run_err", 32'(s_err), 32'(1'b0));

        $display("[TB] randomized run");
        resetDut();
        pend = 2'b00;
        silent = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (s_ack[r]) pend[r] = 1'b0;
                else if (!pend[r] && ($urandom_range(3) == 0)) pend[r] = 1'b1;
            end
            if (silent == 0 && ($urandom_range(499) == 0)) silent = TIMEOUT + 6;
            rv   = (silent > 0) ? 2'b00 : 2'($urandom_range(3));
            if (silent > 0) silent--;
            rr   = ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : 2'b00;
            rn   = ($urandom_range(4) == 0);
            rrst = ($urandom_range(299) == 0);
            applyStimulus(rrst, pend, rv, rr, rn);
            stepCycle(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/link_fanin_arbiter.md
LINK_FANIN_ARBITER -- requirements
Module: link_fanin_arbiter

Interface
REQ-001 Parameter WIDTH_DATA, default 32, data word width per path.
REQ-002 Parameter NUM_ID, default 3, number of leading ID words per message.
REQ-003 Parameter TIMEOUT, default 64, idle-cycle limit per grant; legal range 2..255.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 I_Req  input  2  per-requester message request, bit r = requester r.
REQ-007 O_Ack  output  2  one-hot grant acknowledge.
REQ-008 I_Valid  input  2  per-requester word valid.
REQ-009 I_Rls  input  2  per-requester release flag, marking the last word of a message.
REQ-010 I_Data0 / I_Data1  input  WIDTH_DATA each  requester data.
REQ-011 O_Valid  output  1  shared-link word valid.
REQ-012 O_Data  output  WIDTH_DATA  shared-link data.
REQ-013 O_is_ID  output  1  current O_Valid word is an ID word.
REQ-014 I_Nack  input  1  downstream back-pressure.
REQ-015 O_Nack  output  2  per-requester back-pressure.
REQ-016 O_Sel  output  1  index of the owning requester.
REQ-017 O_is_Busy  output  1  link owned and message not ending.
REQ-018 O_Err  output  1  one-cycle timeout abort pulse.

Function
REQ-019 The FSM SHALL use three states, INIT=0, SEND_ID=1 and RUN=2; any other encoding SHALL return to INIT on the next cycle.
REQ-020 R_Nack SHALL register I_Nack every cycle; an accepted word is acc = I_Valid[R_Sel] & ~R_Nack while in SEND_ID or RUN.
REQ-021 Winner selection in INIT:
- Only one I_Req bit set: that requester wins.
- Both set: requester ~R_Last wins (round-robin).
- Neither set: state stays INIT.
REQ-022 O_Ack[winner] SHALL be combinational and asserted only in the cycle INIT sees a request; R_Sel loads the winner and the FSM moves to SEND_ID on the next edge.
REQ-023 In SEND_ID, R_Cnt SHALL increment on each acc; on the acc that makes NUM_ID words, R_Cnt clears and the FSM moves to RUN.
REQ-024 In RUN, end = acc & I_Rls[R_Sel]; end SHALL move the FSM to INIT and load R_Last <= R_Sel.
REQ-025 acc & I_Rls[R_Sel] in SEND_ID SHALL end the message as in REQ-024 (short message) with R_Cnt cleared and no O_Err.
REQ-026 R_Idle SHALL clear on acc or on entry to SEND_ID, and otherwise increment in SEND_ID/RUN.
REQ-027 When R_Idle reaches TIMEOUT-1 without acc, the following SHALL occur:
- O_Err pulses for that cycle.
- The FSM moves to INIT.
- R_Last <= R_Sel; R_Cnt and R_Idle clear.
REQ-028 O_Valid = I_Valid[R_Sel] in SEND_ID/RUN, else 0; O_Data = R_Sel ? I_Data1 : I_Data0, and O_Data SHALL be 0 when O_Valid=0.
REQ-029 O_is_ID SHALL be high exactly when in SEND_ID and O_Valid=1.
REQ-030 O_Nack[R_Sel] = I_Nack in SEND_ID/RUN; every non-owning requester, and both in INIT, SHALL see O_Nack=1.
REQ-031 O_is_Busy = (state != INIT) & ~end & ~O_Err.
REQ-032 Requests arriving while not in INIT SHALL be ignored and not stored; the requester holds I_Req until acknowledged.
REQ-033 An end and a same-cycle I_Req from the other requester SHALL be granted no earlier than the following INIT cycle (one-cycle turnaround).

Reset
REQ-034 Reset SHALL set state=INIT, R_Sel=0, R_Last=1 (so requester 0 wins the first tie), R_Cnt=0, R_Idle=0, R_Nack=0.
REQ-035 During reset all outputs SHALL be 0 except O_Nack=2'b11.
REQ-036 Reset mid-message SHALL abandon the grant immediately, with no O_Err.

Verification
REQ-037 Single message: I_Req=01, then 3 ID words and 2 data words with Rls on the last -> O_Ack=01 for 1 cycle, O_is_ID high on 3 words, FSM back in INIT, R_Last=0.
REQ-038 Tie: I_Req=11 held across two messages -> grants in order 0, 1, 0; each O_Ack pulse is 1 cycle; at least one INIT cycle between grants.
REQ-039 Back-pressure: I_Nack=1 for 4 cycles mid-RUN -> no acc, R_Cnt frozen, O_Nack[sel]=1, message completes unchanged afterward.
REQ-040 Timeout: grant, then I_Valid=0 for 64 cycles -> O_Err pulses once on cycle 64, FSM returns to INIT, the other pending requester is granted next.
REQ-041 Short message: Rls on the 2nd ID word -> FSM returns to INIT, O_Err=0, R_Cnt=0.
REQ-042 Reset asserted in RUN -> next cycle INIT, O_Valid=0, O_Nack=11, O_Err=0.
